// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: exception-sequencer states and
// the pipeline stage indices used to address the per-stage stall/flush vectors.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_REDIRECT = 2'd3
   } hz_state_e;

   localparam int STG_F = 0;
   localparam int STG_D = 1;
   localparam int STG_E = 2;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-facing bundle of the hazard scoreboard: issue/writeback info, bus
// activity, exception request, and the stall/flush/redirect controls back.
interface hazard_scoreboard_if #(
   parameter int NREG   = 32,
   parameter int REG_W  = 5,
   parameter int STAGES = 5
);
   logic              issue_valid;
   logic [REG_W-1:0]  issue_rs;
   logic [REG_W-1:0]  issue_rt;
   logic [REG_W-1:0]  issue_dst;
   logic              issue_long;
   logic              issue_wr;
   logic              wb_valid;
   logic [REG_W-1:0]  wb_dst;
   logic              wb_long;
   logic              fetch_busy;
   logic              mem_busy;
   logic              mem_req_fire;
   logic              mem_resp_fire;
   logic              except_i;
   logic [31:0]       except_pc_i;
   logic [STAGES-1:0] stall;
   logic [STAGES-1:0] flush;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic [NREG-1:0]   sb_busy;

   modport master (
      output issue_valid, issue_rs, issue_rt, issue_dst, issue_long, issue_wr,
      output wb_valid, wb_dst, wb_long,
      output fetch_busy, mem_busy, mem_req_fire, mem_resp_fire,
      output except_i, except_pc_i,
      input  stall, flush, redirect_valid, redirect_pc, sb_busy
   );

   modport slave (
      input  issue_valid, issue_rs, issue_rt, issue_dst, issue_long, issue_wr,
      input  wb_valid, wb_dst, wb_long,
      input  fetch_busy, mem_busy, mem_req_fire, mem_resp_fire,
      input  except_i, except_pc_i,
      output stall, flush, redirect_valid, redirect_pc, sb_busy
   );
endinterface

// File: rtl/outstanding_cnt.sv
// Count of bus reads issued but not yet fully answered; a request and a final
// response in the same cycle cancel, and a stray response never underflows.
module outstanding_cnt #(
   parameter int MAX_OUT = 4,
   parameter int OUT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             inc,
   input  logic             dec,
   output logic [OUT_W-1:0] count,
   output logic             full,
   output logic             zero_next
);
   logic [OUT_W-1:0] count_q;
   logic [OUT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && !dec) begin
         count_d = count_q + OUT_W'(1);
      end else if (dec && !inc && (count_q != '0)) begin
         count_d = count_q - OUT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A response arriving this cycle frees a slot, so it lifts the full condition.
   assign count     = count_q;
   assign full      = (count_q == OUT_W'(MAX_OUT)) && !dec;
   assign zero_next = (count_d == '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: RAW interlock on long-latency results, bus-read throttling
// and the exception flush -> drain -> redirect sequencer of the in-order pipe.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREG    = 32,
   parameter int REG_W   = 5,
   parameter int STAGES  = 5,
   parameter int MAX_OUT = 4
) (
   input logic                clk,
   input logic                resetn,
   hazard_scoreboard_if.slave hz
);
   localparam int OUT_W = $clog2(MAX_OUT + 1);

   hz_state_e         state_q, state_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic [31:0]       pc_q, pc_d;
   logic [OUT_W-1:0]  count;
   logic              cnt_full;
   logic              cnt_zero_next;
   logic              raw_hz;
   logic              ext;
   logic              issue_fire;
   logic [STAGES-1:0] stall_c;
   logic [STAGES-1:0] flush_c;
   logic              redirect_c;

   outstanding_cnt #(
      .MAX_OUT (MAX_OUT),
      .OUT_W   (OUT_W)
   ) u_cnt (
      .clk       (clk),
      .resetn    (resetn),
      .inc       (hz.mem_req_fire),
      .dec       (hz.mem_resp_fire),
      .count     (count),
      .full      (cnt_full),
      .zero_next (cnt_zero_next)
   );

   assign raw_hz = hz.issue_valid & (busy_q[hz.issue_rs] | busy_q[hz.issue_rt]);
   assign ext    = hz.fetch_busy | hz.mem_busy;

   // Hazards and bus stalls only matter while running; the exception sequence owns the pipe otherwise.
   always_comb begin
      stall_c    = '0;
      flush_c    = '0;
      redirect_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ext) begin
               stall_c = '1;
            end else begin
               stall_c[STG_F] = cnt_full | raw_hz;
               stall_c[STG_D] = raw_hz;
               flush_c[STG_E] = raw_hz;
            end
         end
         ST_FLUSH: begin
            flush_c = '1;
         end
         ST_DRAIN: begin
            stall_c = '1;
         end
         ST_REDIRECT: begin
            flush_c        = '1;
            flush_c[STG_F] = 1'b0;
            redirect_c     = 1'b1;
         end
         default: begin
            stall_c = '0;
         end
      endcase
   end

   assign issue_fire = hz.issue_valid & ~stall_c[STG_D] & (state_q == ST_IDLE);

   always_comb begin
      busy_d = busy_q;
      if (state_q == ST_FLUSH) begin
         busy_d = '0;
      end else begin
         if (hz.wb_valid && hz.wb_long) begin
            busy_d[hz.wb_dst] = 1'b0;
         end
         if (issue_fire && hz.issue_wr && hz.issue_long) begin
            busy_d[hz.issue_dst] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   // FLUSH decides on the count it sees, not on a response landing alongside it.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         ST_IDLE: begin
            if (hz.except_i) begin
               state_d = ST_FLUSH;
               pc_d    = hz.except_pc_i;
            end
         end
         ST_FLUSH:    state_d = (count != '0) ? ST_DRAIN : ST_REDIRECT;
         ST_DRAIN:    state_d = cnt_zero_next ? ST_REDIRECT : ST_DRAIN;
         ST_REDIRECT: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         busy_q  <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         pc_q    <= pc_d;
      end
   end

   assign hz.stall          = stall_c;
   assign hz.flush          = flush_c;
   assign hz.redirect_valid = redirect_c;
   assign hz.redirect_pc    = pc_q;
   assign hz.sb_busy        = busy_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios against fixed
// expectations, then randomized traffic against a behavioural model.
module tb_hazard_scoreboard;
   localparam int NREG    = 32;
   localparam int REG_W   = 5;
   localparam int STAGES  = 5;
   localparam int MAX_OUT = 4;

   localparam int PH_RUN   = 0;
   localparam int PH_FLUSH = 1;
   localparam int PH_DRAIN = 2;
   localparam int PH_REDIR = 3;

   logic clk = 1'b0;
   logic resetn;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.NREG(NREG), .REG_W(REG_W), .STAGES(STAGES)) hzi ();

   hazard_scoreboard #(
      .NREG    (NREG),
      .REG_W   (REG_W),
      .STAGES  (STAGES),
      .MAX_OUT (MAX_OUT)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .hz     (hzi)
   );

   task automatic idle_inputs();
      hzi.issue_valid   = 1'b0;
      hzi.issue_rs      = '0;
      hzi.issue_rt      = '0;
      hzi.issue_dst     = '0;
      hzi.issue_long    = 1'b0;
      hzi.issue_wr      = 1'b0;
      hzi.wb_valid      = 1'b0;
      hzi.wb_dst        = '0;
      hzi.wb_long       = 1'b0;
      hzi.fetch_busy    = 1'b0;
      hzi.mem_busy      = 1'b0;
      hzi.mem_req_fire  = 1'b0;
      hzi.mem_resp_fire = 1'b0;
      hzi.except_i      = 1'b0;
      hzi.except_pc_i   = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   task automatic issue_long_to(input int dst);
      hzi.issue_valid = 1'b1;
      hzi.issue_rs    = '0;
      hzi.issue_rt    = '0;
      hzi.issue_dst   = REG_W'(dst);
      hzi.issue_long  = 1'b1;
      hzi.issue_wr    = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 1'b1;
      #2;
      resetn = 1'b0;
      #1;
      total++; if (hzi.stall !== 5'b00000) begin bad++; $display("FAIL reset_stall: got %b want 00000", hzi.stall); end
      total++; if (hzi.flush !== 5'b00000) begin bad++; $display("FAIL reset_flush: got %b want 00000", hzi.flush); end
      total++; if (hzi.redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_redirect: got %b want 0", hzi.redirect_valid); end
      total++; if (hzi.sb_busy !== 32'h0) begin bad++; $display("FAIL reset_busy: got %h want 0", hzi.sb_busy); end
      tick();
      resetn = 1'b1;
      issue_long_to(8);
      tick();
      idle_inputs();
      #1;
      total++; if (hzi.sb_busy !== 32'h0000_0100) begin bad++; $display("FAIL reset_pre_busy: got %h want 00000100", hzi.sb_busy); end
      resetn = 1'b0;
      #1;
      total++; if (hzi.sb_busy !== 32'h0) begin bad++; $display("FAIL reset_async_busy: got %h want 0", hzi.sb_busy); end
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_raw_stall();
      issue_long_to(8);
      hzi.issue_rs = REG_W'(1);
      hzi.issue_rt = REG_W'(2);
      #1;
      total++; if (hzi.stall !== 5'b00000) begin bad++; $display("FAIL raw_lw_stall: got %b want 00000", hzi.stall); end
      tick();
      hzi.issue_rs   = REG_W'(8);
      hzi.issue_rt   = REG_W'(3);
      hzi.issue_dst  = REG_W'(9);
      hzi.issue_long = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (hzi.stall !== 5'b00011) begin bad++; $display("FAIL raw_stall[%0d]: got %b want 00011", i, hzi.stall); end
         total++; if (hzi.flush !== 5'b00100) begin bad++; $display("FAIL raw_flush[%0d]: got %b want 00100", i, hzi.flush); end
         if (i == 2) begin
            hzi.wb_valid = 1'b1;
            hzi.wb_dst   = REG_W'(8);
            hzi.wb_long  = 1'b1;
         end
         tick();
      end
      hzi.wb_valid = 1'b0;
      #1;
      total++; if (hzi.stall !== 5'b00000) begin bad++; $display("FAIL raw_release_stall: got %b want 00000", hzi.stall); end
      total++; if (hzi.flush !== 5'b00000) begin bad++; $display("FAIL raw_release_flush: got %b want 00000", hzi.flush); end
      idle_inputs();
      tick();
   endtask

   task automatic test_set_clear();
      issue_long_to(8);
      hzi.wb_valid = 1'b1;
      hzi.wb_dst   = REG_W'(8);
      hzi.wb_long  = 1'b1;
      tick();
      idle_inputs();
      #1;
      total++; if (hzi.sb_busy[8] !== 1'b1) begin bad++; $display("FAIL setclr_set_wins: got %b want 1", hzi.sb_busy[8]); end
      hzi.wb_valid = 1'b1;
      hzi.wb_dst   = REG_W'(8);
      hzi.wb_long  = 1'b1;
      tick();
      idle_inputs();
      #1;
      total++; if (hzi.sb_busy[8] !== 1'b0) begin bad++; $display("FAIL setclr_clear: got %b want 0", hzi.sb_busy[8]); end
      issue_long_to(0);
      tick();
      idle_inputs();
      #1;
      total++; if (hzi.sb_busy !== 32'h0) begin bad++; $display("FAIL setclr_r0: got %h want 0", hzi.sb_busy); end
   endtask

   task automatic test_outstanding();
      idle_inputs();
      hzi.mem_req_fire = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (hzi.stall[0] !== 1'b0) begin bad++; $display("FAIL out_fill[%0d]: got %b want 0", i, hzi.stall[0]); end
         tick();
      end
      hzi.mem_req_fire = 1'b0;
      #1;
      total++; if (hzi.stall[0] !== 1'b1) begin bad++; $display("FAIL out_full: got %b want 1", hzi.stall[0]); end
      hzi.mem_req_fire  = 1'b1;
      hzi.mem_resp_fire = 1'b1;
      #1;
      total++; if (hzi.stall[0] !== 1'b0) begin bad++; $display("FAIL out_both: got %b want 0", hzi.stall[0]); end
      tick();
      hzi.mem_req_fire  = 1'b0;
      hzi.mem_resp_fire = 1'b0;
      #1;
      total++; if (hzi.stall[0] !== 1'b1) begin bad++; $display("FAIL out_still4: got %b want 1", hzi.stall[0]); end
      hzi.mem_resp_fire = 1'b1;
      repeat (4) tick();
      hzi.mem_resp_fire = 1'b0;
      tick();
   endtask

   task automatic test_exception_drain();
      issue_long_to(5);
      hzi.mem_req_fire = 1'b1;
      tick();
      idle_inputs();
      hzi.mem_req_fire = 1'b1;
      tick();
      hzi.mem_req_fire = 1'b0;
      hzi.except_i     = 1'b1;
      hzi.except_pc_i  = 32'hbfc0_0380;
      #1;
      total++; if (hzi.stall !== 5'b00000) begin bad++; $display("FAIL exc_idle_stall: got %b want 00000", hzi.stall); end
      tick();
      hzi.except_i    = 1'b0;
      hzi.except_pc_i = '0;
      #1;
      total++; if (hzi.flush !== 5'b11111) begin bad++; $display("FAIL exc_flush: got %b want 11111", hzi.flush); end
      total++; if (hzi.stall !== 5'b00000) begin bad++; $display("FAIL exc_flush_stall: got %b want 00000", hzi.stall); end
      tick();
      #1;
      total++; if (hzi.sb_busy !== 32'h0) begin bad++; $display("FAIL exc_sb_clear: got %h want 0", hzi.sb_busy); end
      total++; if (hzi.stall !== 5'b11111) begin bad++; $display("FAIL exc_drain0: got %b want 11111", hzi.stall); end
      hzi.mem_resp_fire = 1'b1;
      tick();
      #1;
      total++; if (hzi.stall !== 5'b11111) begin bad++; $display("FAIL exc_drain1: got %b want 11111", hzi.stall); end
      total++; if (hzi.redirect_valid !== 1'b0) begin bad++; $display("FAIL exc_drain1_redir: got %b want 0", hzi.redirect_valid); end
      tick();
      hzi.mem_resp_fire = 1'b0;
      #1;
      total++; if (hzi.redirect_valid !== 1'b1) begin bad++; $display("FAIL exc_redir_valid: got %b want 1", hzi.redirect_valid); end
      total++; if (hzi.redirect_pc !== 32'hbfc0_0380) begin bad++; $display("FAIL exc_redir_pc: got %h want bfc00380", hzi.redirect_pc); end
      total++; if (hzi.flush !== 5'b11110) begin bad++; $display("FAIL exc_redir_flush: got %b want 11110", hzi.flush); end
      total++; if (hzi.stall !== 5'b00000) begin bad++; $display("FAIL exc_redir_stall: got %b want 00000", hzi.stall); end
      tick();
      #1;
      total++; if (hzi.redirect_valid !== 1'b0) begin bad++; $display("FAIL exc_after_redir: got %b want 0", hzi.redirect_valid); end
      total++; if (hzi.flush !== 5'b00000) begin bad++; $display("FAIL exc_after_flush: got %b want 00000", hzi.flush); end
   endtask

   task automatic test_exception_nodrain();
      idle_inputs();
      hzi.except_i    = 1'b1;
      hzi.except_pc_i = 32'h8000_0180;
      tick();
      hzi.except_i = 1'b0;
      #1;
      total++; if (hzi.flush !== 5'b11111) begin bad++; $display("FAIL nod_flush: got %b want 11111", hzi.flush); end
      tick();
      hzi.except_i    = 1'b1;
      hzi.except_pc_i = 32'h1234_5678;
      #1;
      total++; if (hzi.redirect_valid !== 1'b1) begin bad++; $display("FAIL nod_redir: got %b want 1", hzi.redirect_valid); end
      total++; if (hzi.redirect_pc !== 32'h8000_0180) begin bad++; $display("FAIL nod_redir_pc: got %h want 80000180", hzi.redirect_pc); end
      tick();
      hzi.except_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++; if (hzi.flush !== 5'b00000) begin bad++; $display("FAIL nod_ignored_flush[%0d]: got %b want 00000", i, hzi.flush); end
         total++; if (hzi.redirect_valid !== 1'b0) begin bad++; $display("FAIL nod_ignored_redir[%0d]: got %b want 0", i, hzi.redirect_valid); end
         tick();
      end
   endtask

   task automatic test_ext_and_reset_drain();
      issue_long_to(8);
      tick();
      idle_inputs();
      hzi.issue_valid = 1'b1;
      hzi.issue_rs    = REG_W'(8);
      hzi.mem_busy    = 1'b1;
      #1;
      total++; if (hzi.stall !== 5'b11111) begin bad++; $display("FAIL ext_stall: got %b want 11111", hzi.stall); end
      total++; if (hzi.flush !== 5'b00000) begin bad++; $display("FAIL ext_flush: got %b want 00000", hzi.flush); end
      idle_inputs();
      hzi.mem_req_fire = 1'b1;
      tick();
      tick();
      hzi.mem_req_fire = 1'b0;
      hzi.except_i     = 1'b1;
      hzi.except_pc_i  = 32'hdead_beef;
      tick();
      hzi.except_i = 1'b0;
      tick();
      #1;
      total++; if (hzi.stall !== 5'b11111) begin bad++; $display("FAIL rstdrain_in_drain: got %b want 11111", hzi.stall); end
      resetn = 1'b0;
      #1;
      total++; if (hzi.stall !== 5'b00000) begin bad++; $display("FAIL rstdrain_stall: got %b want 00000", hzi.stall); end
      total++; if (hzi.sb_busy !== 32'h0) begin bad++; $display("FAIL rstdrain_busy: got %h want 0", hzi.sb_busy); end
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (hzi.redirect_valid !== 1'b0) begin bad++; $display("FAIL rstdrain_no_redir[%0d]: got %b want 0", i, hzi.redirect_valid); end
         total++; if (hzi.stall !== 5'b00000) begin bad++; $display("FAIL rstdrain_idle_stall[%0d]: got %b want 00000", i, hzi.stall); end
         tick();
      end
   endtask

   task automatic test_random();
      bit                m_busy [NREG];
      int                m_cnt;
      int                m_phase;
      logic [31:0]       m_pc;
      logic [STAGES-1:0] e_stall;
      logic [STAGES-1:0] e_flush;
      logic              e_redir;
      logic [NREG-1:0]   e_busy;
      bit                hazard;
      bit                bus_stall;
      bit                fire;
      int                new_cnt;

      do_reset();
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      m_cnt   = 0;
      m_phase = PH_RUN;
      m_pc    = '0;

      for (int cyc = 0; cyc < 400; cyc++) begin
         hzi.issue_valid   = ($urandom_range(0, 3) != 0);
         hzi.issue_rs      = REG_W'($urandom_range(0, 7));
         hzi.issue_rt      = REG_W'($urandom_range(0, 7));
         hzi.issue_dst     = REG_W'($urandom_range(0, 7));
         hzi.issue_long    = ($urandom_range(0, 2) == 0);
         hzi.issue_wr      = ($urandom_range(0, 3) != 0);
         hzi.wb_valid      = ($urandom_range(0, 2) == 0);
         hzi.wb_dst        = REG_W'($urandom_range(0, 7));
         hzi.wb_long       = ($urandom_range(0, 1) == 0);
         hzi.fetch_busy    = ($urandom_range(0, 9) == 0);
         hzi.mem_busy      = ($urandom_range(0, 9) == 0);
         hzi.except_i      = ($urandom_range(0, 39) == 0);
         hzi.except_pc_i   = $urandom();
         hzi.mem_resp_fire = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         hzi.mem_req_fire  = (m_phase == PH_RUN) && ((m_cnt < MAX_OUT) || hzi.mem_resp_fire)
                             && ($urandom_range(0, 2) == 0);
         #1;

         hazard    = hzi.issue_valid && (m_busy[hzi.issue_rs] || m_busy[hzi.issue_rt]);
         bus_stall = hzi.fetch_busy || hzi.mem_busy;
         e_stall   = '0;
         e_flush   = '0;
         e_redir   = 1'b0;
         if (m_phase == PH_RUN) begin
            if (bus_stall) begin
               e_stall = '1;
            end else begin
               e_stall[0] = hazard || ((m_cnt == MAX_OUT) && !hzi.mem_resp_fire);
               e_stall[1] = hazard;
               e_flush[2] = hazard;
            end
         end else if (m_phase == PH_FLUSH) begin
            e_flush = '1;
         end else if (m_phase == PH_DRAIN) begin
            e_stall = '1;
         end else begin
            e_flush = {{(STAGES-1){1'b1}}, 1'b0};
            e_redir = 1'b1;
         end
         for (int i = 0; i < NREG; i++) e_busy[i] = m_busy[i];

         total++; if (hzi.stall !== e_stall) begin bad++; $display("FAIL rnd_stall@%0d: got %b want %b", cyc, hzi.stall, e_stall); end
         total++; if (hzi.flush !== e_flush) begin bad++; $display("FAIL rnd_flush@%0d: got %b want %b", cyc, hzi.flush, e_flush); end
         total++; if (hzi.redirect_valid !== e_redir) begin bad++; $display("FAIL rnd_redir@%0d: got %b want %b", cyc, hzi.redirect_valid, e_redir); end
         total++; if (hzi.sb_busy !== e_busy) begin bad++; $display("FAIL rnd_busy@%0d: got %h want %h", cyc, hzi.sb_busy, e_busy); end
         if (e_redir) begin
            total++; if (hzi.redirect_pc !== m_pc) begin bad++; $display("FAIL rnd_pc@%0d: got %h want %h", cyc, hzi.redirect_pc, m_pc); end
         end

         fire = (m_phase == PH_RUN) && hzi.issue_valid && !e_stall[1];
         if (m_phase == PH_FLUSH) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
         end else begin
            if (hzi.wb_valid && hzi.wb_long) m_busy[hzi.wb_dst] = 1'b0;
            if (fire && hzi.issue_wr && hzi.issue_long && (hzi.issue_dst != 0)) m_busy[hzi.issue_dst] = 1'b1;
         end

         new_cnt = m_cnt;
         if (hzi.mem_req_fire && !hzi.mem_resp_fire) new_cnt = m_cnt + 1;
         else if (hzi.mem_resp_fire && !hzi.mem_req_fire && (m_cnt > 0)) new_cnt = m_cnt - 1;

         case (m_phase)
            PH_RUN: begin
               if (hzi.except_i) begin
                  m_phase = PH_FLUSH;
                  m_pc    = hzi.except_pc_i;
               end
            end
            PH_FLUSH: m_phase = (m_cnt != 0) ? PH_DRAIN : PH_REDIR;
            PH_DRAIN: if (new_cnt == 0) m_phase = PH_REDIR;
            default:  m_phase = PH_RUN;
         endcase
         m_cnt = new_cnt;
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      test_reset();
      test_raw_stall();
      test_set_clear();
      test_outstanding();
      test_exception_drain();
      test_exception_nodrain();
      test_ext_and_reset_drain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
